adc_pll_supervisor: RTL and testbench

//   Consumer-side controller for the ADCclock PLL. Runs on refclk. Drives the PLL reset and watches its

---
 rtl/adc_clk_pkg.sv | 26 ++
 rtl/bit_sync.sv | 22 ++
 rtl/adc_pll_supervisor.sv | 152 +++++++++++++++
 tb/tb_adc_pll_supervisor.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_clk_pkg.sv
// Shared types and default timing for the ADC clock PLL supervisor.
// Holds the FSM state encoding, default cycle counts and a width helper.
package adc_clk_pkg;

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam int unsigned DEF_PLL_RST_CYCLES      = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int unsigned DEF_STABLE_CYCLES       = 1024;
  localparam int unsigned DEF_MAX_RETRIES         = 7;
  localparam int unsigned DEF_SYNC_STAGES         = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop level synchronizer with asynchronous active-low clear.
// Used for pll_locked here and by ADC-domain consumers of adc_rst_n.
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: flops are written with <= so every stage samples the value from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/adc_pll_supervisor.sv
// Sequences the ADC-clock PLL reset, qualifies lock and gates the ADC-domain reset.
// Retries failed lock attempts a bounded number of times before latching a fault.
module adc_pll_supervisor
  import adc_clk_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned STABLE_CYCLES       = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int unsigned SYNC_STAGES         = DEF_SYNC_STAGES
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       adc_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [2:0] retry_count,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state
);

  localparam int unsigned CNT_W =
    $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES) + 1);
  localparam int unsigned STB_W = $clog2(STABLE_CYCLES + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STB_W-1:0] stb_q, stb_d;
  logic [2:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             pll_rst_q, pll_rst_d;
  logic             adc_rst_n_q, adc_rst_n_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             locked_s;

  bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  // cnt_q times both the PLL reset pulse and the whole lock attempt (WAIT_LOCK + STABLE);
  // stb_q separately counts the current run of consecutive locked cycles.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    stb_d   = stb_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    case (state_q)
      ST_RST_PLL: begin
        if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK, ST_STABLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          cnt_d = '0;
          if (retry_q < 3'(MAX_RETRIES)) begin
            retry_d = retry_q + 3'd1;
            state_d = ST_RST_PLL;
          end else begin
            state_d = ST_FAULT;
          end
        end else if (state_q == ST_WAIT_LOCK) begin
          if (locked_s) begin
            state_d = ST_STABLE;
            stb_d   = '0;
          end
        end else if (!locked_s) begin
          stb_d = '0;
        end else if (stb_q == STB_W'(STABLE_CYCLES)) begin
          state_d = ST_RUN;
          retry_d = '0;
        end else begin
          stb_d = stb_q + STB_W'(1);
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_RST_PLL;
          cnt_d   = '0;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end
      end
      ST_FAULT: ;
      default: begin
        state_d = ST_RST_PLL;
        cnt_d   = '0;
      end
    endcase

    if (force_relock) begin
      state_d = ST_RST_PLL;
      retry_d = '0;
      cnt_d   = '0;
    end
  end

  // Outputs are decoded from the next state and registered, so they line up with state_q.
  always_comb begin
    pll_rst_d   = (state_d == ST_RST_PLL) || (state_d == ST_FAULT);
    adc_rst_n_d = (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

  // NOTE: only control/status flops exist here, so all of them take the async reset value.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST_PLL;
      cnt_q       <= '0;
      stb_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      adc_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stb_q       <= stb_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_q   <= pll_rst_d;
      adc_rst_n_q <= adc_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_rst         = pll_rst_q;
  assign adc_rst_n       = adc_rst_n_q;
  assign ready           = ready_q;
  assign fault           = fault_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = loss_q;
  assign state           = state_q;

endmodule

// File: tb/tb_adc_pll_supervisor.sv
// Directed self-checking bench for adc_pll_supervisor with short test timing.
// Inputs change and outputs are sampled 1 ns after the rising refclk edge.
module tb_adc_pll_supervisor;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       adc_rst_n;
  logic       ready;
  logic       fault;
  logic [2:0] retry_count;
  logic [7:0] lock_loss_count;
  logic [2:0] state;

  int vectors;
  int miscompares;

  localparam int SEL_PLL_RST = 0;
  localparam int SEL_READY   = 1;
  localparam int SEL_ADC_RST = 2;
  localparam int SEL_RETRY   = 3;
  localparam int SEL_STATE   = 4;

  adc_pll_supervisor #(
    .PLL_RST_CYCLES      (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .STABLE_CYCLES       (8),
    .MAX_RETRIES         (2),
    .SYNC_STAGES         (2)
  ) dut (
    .refclk          (refclk),
    .rst_n           (rst_n),
    .pll_locked      (pll_locked),
    .force_relock    (force_relock),
    .pll_rst         (pll_rst),
    .adc_rst_n       (adc_rst_n),
    .ready           (ready),
    .fault           (fault),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count),
    .state           (state)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      SEL_PLL_RST: return 32'(pll_rst);
      SEL_READY:   return 32'(ready);
      SEL_ADC_RST: return 32'(adc_rst_n);
      SEL_RETRY:   return 32'(retry_count);
      default:     return 32'(state);
    endcase
  endfunction

  // Ticks until the probed output equals val; n = ticks taken, or budget on expiry.
  task automatic wait_val(input int sel, input logic [31:0] val, input int budget, output int n);
    n = 0;
    while (probe(sel) !== val && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"},   32'(state), 0);
    check({tag, "_pll_rst"}, 32'(pll_rst), 1);
    check({tag, "_adc_rst"}, 32'(adc_rst_n), 0);
    check({tag, "_ready"},   32'(ready), 0);
    check({tag, "_fault"},   32'(fault), 0);
    check({tag, "_retry"},   32'(retry_count), 0);
    check({tag, "_loss"},    32'(lock_loss_count), 0);
  endtask

  // From RUN: force a relock, drop pll_locked for one cycle low_at cycles after the force
  // edge, then count cycles until ready returns.
  task automatic glitch_after_force(input string tag, input int low_at, input int exp_ticks);
    int n;
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    check({tag, "_force_state"}, 32'(state), 0);
    check({tag, "_force_adc"},   32'(adc_rst_n), 0);
    repeat (low_at) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    check({tag, "_in_stable"}, 32'(state), 2);
    wait_val(SEL_READY, 1, 40, n);
    check({tag, "_ready_ticks"}, 32'(n), 32'(exp_ticks));
  endtask

  initial begin
    int n;
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    force_relock = 1'b0;

    // Reset values and pll_rst pulse width.
    repeat (3) tick();
    check_reset("reset");
    rst_n = 1'b1;
    wait_val(SEL_PLL_RST, 0, 20, n);
    check("t1_pll_rst_width", 32'(n), 4);
    check("t1_wait_state", 32'(state), 1);

    // Nominal lock: ready 11 cycles after the first edge that samples lock high.
    repeat (3) tick();
    pll_locked = 1'b1;
    tick();
    check("t1_not_ready_yet", 32'(ready), 0);
    wait_val(SEL_READY, 1, 40, n);
    check("t1_ready_latency", 32'(n), 11);
    check("t1_adc_rst_n", 32'(adc_rst_n), 1);
    check("t1_run_state", 32'(state), 3);
    check("t1_retry", 32'(retry_count), 0);

    // One-cycle lock drop in RUN.
    pll_locked = 1'b0;
    tick();
    n = 1;
    pll_locked = 1'b1;
    while (adc_rst_n !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    check("t3_fall_latency", 32'(n), 3);
    check("t3_loss_count", 32'(lock_loss_count), 1);
    check("t3_ready_low", 32'(ready), 0);
    check("t3_rst_state", 32'(state), 0);
    wait_val(SEL_PLL_RST, 0, 20, n);
    check("t3_pll_rst_width", 32'(n), 4);
    wait_val(SEL_READY, 1, 40, n);
    check("t3_relock_ticks", 32'(n), 10);

    // Glitch at STABLE count 5, then a drop on the very cycle STABLE would complete.
    glitch_after_force("t4", 8, 11);
    check("t4_loss_kept", 32'(lock_loss_count), 1);
    glitch_after_force("edge", 11, 11);

    // Lock never asserts: two retries, then sticky fault.
    pll_locked   = 1'b0;
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    wait_val(SEL_RETRY, 1, 60, n);
    check("t2_retry1_ticks", 32'(n), 24);
    check("t2_retry1_state", 32'(state), 0);
    wait_val(SEL_RETRY, 2, 60, n);
    check("t2_retry2_ticks", 32'(n), 24);
    wait_val(SEL_STATE, 4, 60, n);
    check("t2_fault_ticks", 32'(n), 24);
    check("t2_fault", 32'(fault), 1);
    check("t2_pll_rst", 32'(pll_rst), 1);
    repeat (50) tick();
    check("t2_fault_held", 32'(state), 4);
    check("t2_pll_rst_held", 32'(pll_rst), 1);
    check("t2_retry_held", 32'(retry_count), 2);

    // force_relock out of FAULT.
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    check("t5_fault", 32'(fault), 0);
    check("t5_retry", 32'(retry_count), 0);
    check("t5_state", 32'(state), 0);
    check("t5_loss_kept", 32'(lock_loss_count), 1);

    // Asynchronous reset in the middle of STABLE.
    pll_locked = 1'b1;
    wait_val(SEL_STATE, 2, 20, n);
    check("t6_reach_stable", 32'(state), 2);
    tick();
    #2 rst_n = 1'b0;
    #1 check_reset("t6_stable_rst");
    tick();
    rst_n = 1'b1;
    wait_val(SEL_READY, 1, 40, n);
    check("t6_back_to_run", 32'(ready), 1);

    // 300 lock losses saturate the counter.
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      wait_val(SEL_READY, 0, 10, n);
      wait_val(SEL_READY, 1, 40, n);
    end
    check("t6_loss_ready", 32'(ready), 1);
    check("t6_loss_sat", 32'(lock_loss_count), 255);

    // Asynchronous reset while in RUN.
    #2 rst_n = 1'b0;
    #1 check_reset("t6_run_rst");
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
